// File: rtl/exec_unit_seq.sv
// -----------------------------------------------------------------------------
// exec_unit_seq
//   Sequenced execution unit. Owns a DEPTH-word operand memory and runs one ALU
//   operation per command: read a from addr1, read b from addr2, execute the
//   opcode, write the result back to addr3. One FSM state per clock:
//   IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               command request, sampled in IDLE only
//   opcode/addr1..3     command fields, captured together with start
//   load_en/addr/data   host write port, honoured in IDLE only
//   dbg_addr/dbg_data   combinational debug read of the memory
//   a, b, out           latched operands and result of the last command
//   flag                {C,Z,S,V} of the last valid operation
//   busy                high whenever the FSM is not in IDLE
//   done                one-cycle completion pulse
//   err                 one-cycle pulse alongside done for an invalid opcode
//
// Addresses >= DEPTH read as zero and drop writes on every port.
// -----------------------------------------------------------------------------
module exec_unit_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out,
    output logic [3:0]        flag,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_INC  = 4'd8;
    localparam logic [3:0] OP_DEC  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;

    localparam logic [DATA_W:0] ONE_EXT = (DATA_W+1)'(1);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr1_q, addr2_q, addr3_q;
    logic [3:0]        flag_hold;

    logic [DATA_W-1:0] result;
    logic [DATA_W:0]   ext;
    logic              c_nx, v_nx;
    logic [3:0]        flag_nx;
    logic              op_valid;

    function automatic logic in_range(input logic [ADDR_W-1:0] ad);
        return 32'(ad) < DEPTH;
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] ad);
        return in_range(ad) ? mem[ad] : '0;
    endfunction

    assign dbg_data = mem_rd(dbg_addr);
    assign busy     = (state != IDLE);
    assign op_valid = (op_q <= OP_PASS);

    // ---------------- FSM ----------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RD_A;
            RD_A:    state_nx = RD_B;
            RD_B:    state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- ALU ----------------
    always_comb begin
        ext    = '0;
        result = '0;
        c_nx   = 1'b0;
        v_nx   = 1'b0;
        case (op_q)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[MSB:0];
                c_nx   = ext[DATA_W];
                v_nx   = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // The extra top bit of the extended difference is the borrow (a < b).
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[MSB:0];
                c_nx   = ext[DATA_W];
                v_nx   = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL: begin
                result = {a[MSB-1:0], 1'b0};
                c_nx   = a[MSB];
            end
            OP_SHR: begin
                result = {1'b0, a[MSB:1]};
                c_nx   = a[0];
            end
            OP_INC: begin
                ext    = {1'b0, a} + ONE_EXT;
                result = ext[MSB:0];
                c_nx   = ext[DATA_W];
                v_nx   = !a[MSB] && result[MSB];
            end
            OP_DEC: begin
                ext    = {1'b0, a} - ONE_EXT;
                result = ext[MSB:0];
                c_nx   = ext[DATA_W];
                v_nx   = a[MSB] && !result[MSB];
            end
            OP_PASS: result = a;
            default: result = '0;
        endcase
        flag_nx = {c_nx, (result == '0), result[MSB], v_nx};
    end

    // ---------------- Datapath and memory ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            addr3_q   <= '0;
            a         <= '0;
            b         <= '0;
            out       <= '0;
            flag      <= '0;
            flag_hold <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            // NOTE: the memory is cleared by reset, so it is built from flops
            // rather than a RAM macro; keep DEPTH modest.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= opcode;
                        addr1_q <= addr1;
                        addr2_q <= addr2;
                        addr3_q <= addr3;
                    end
                    if (load_en && in_range(load_addr)) mem[load_addr] <= load_data;
                end
                RD_A: a <= mem_rd(addr1_q);
                RD_B: b <= mem_rd(addr2_q);
                EXEC: begin
                    out       <= result;
                    flag_hold <= flag_nx;
                end
                WB: begin
                    done <= 1'b1;
                    if (op_valid) begin
                        if (in_range(addr3_q)) mem[addr3_q] <= out;
                        flag <= flag_hold;
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_exec_unit_seq
//   Scoreboard bench for exec_unit_seq. Stimulus computes each command's
//   expected outcome from an arithmetic reference model and queues it; an
//   independent monitor pops and compares whenever done is presented.
// -----------------------------------------------------------------------------
module tb_exec_unit_seq;

    localparam int W     = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int M     = 1 << W;
    localparam int H     = 1 << (W - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    opcode = '0;
    logic [AW-1:0] addr1 = '0, addr2 = '0, addr3 = '0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [W-1:0]  dbg_data, a, b, out;
    logic [3:0]    flag;
    logic          busy, done, err;

    exec_unit_seq #(.DATA_W(W), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .a(a), .b(b), .out(out), .flag(flag),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         av, bv, res;
        logic [3:0] flg;
        bit         is_err;
        bit         chk_out;
        longint     done_cyc;
    } exp_t;

    exp_t       sb[$];
    int         model_mem[DEPTH];
    logic [3:0] model_flag = '0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= H) ? v - M : v;
    endfunction

    // Reference behaviour straight from the opcode table: plain integer math.
    function automatic void ref_op(input int op, input int av, input int bv,
                                   output int r, output logic [3:0] f, output bit ok);
        int  s;
        bit  c, v;
        c = 0; v = 0; ok = 1; r = 0;
        case (op)
            0, 8: begin
                int bb = (op == 8) ? 1 : bv;
                s = av + bb; r = s % M; c = (s >= M);
                s = to_signed(av) + to_signed(bb); v = (s > H - 1) || (s < -H);
            end
            1, 9: begin
                int bb = (op == 9) ? 1 : bv;
                r = (av - bb + M) % M; c = (av < bb);
                s = to_signed(av) - to_signed(bb); v = (s > H - 1) || (s < -H);
            end
            2:  r = av & bv;
            3:  r = av | bv;
            4:  r = av ^ bv;
            5:  r = M - 1 - av;
            6:  begin r = (av * 2) % M; c = (av >= H); end
            7:  begin r = av / 2; c = (av % 2) == 1; end
            10: r = av;
            default: ok = 0;
        endcase
        f = {c, (r == 0), (r >= H), v};
    endfunction

    // Monitor: independent of stimulus, reacts only to what the DUT presents.
    always @(negedge clk) begin
        if (err) check("err_implies_done", done, 1);
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("a_latched", a, e.av);
                check("b_latched", b, e.bv);
                if (e.chk_out) check("out_result", out, e.res);
                check("flag", flag, e.flg);
                check("err_pulse", err, e.is_err);
                check("done_latency", cyc, e.done_cyc);
            end
        end
    end

    // Called at a negedge with the FSM idle; returns #1 after the sampling edge.
    task automatic issue(input int op, input int a1, input int a2, input int a3,
                         input bit with_load = 0, input int la = 0, input int ld = 0);
        exp_t e;
        int   r;
        logic [3:0] f;
        bit   ok;
        if (with_load) begin
            load_en = 1; load_addr = AW'(la); load_data = W'(ld);
            model_mem[la] = ld;
        end
        start = 1; opcode = 4'(op); addr1 = AW'(a1); addr2 = AW'(a2); addr3 = AW'(a3);
        ref_op(op, model_mem[a1], model_mem[a2], r, f, ok);
        e.av = model_mem[a1]; e.bv = model_mem[a2]; e.res = r;
        e.chk_out = ok; e.is_err = !ok;
        if (ok) begin
            model_mem[a3] = r;
            model_flag    = f;
        end
        e.flg = model_flag;
        e.done_cyc = cyc + 5;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 0; load_en = 0;
        check("busy_after_start", busy, 1);
    endtask

    // Returns at the first negedge with busy low (the done cycle, if one is pending).
    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic load(input int ad, input int d);
        load_en = 1; load_addr = AW'(ad); load_data = W'(d);
        model_mem[ad] = d;
        @(posedge clk);
        #1 load_en = 0;
        @(negedge clk);
    endtask

    task automatic dbg_chk(input string nm, input int ad);
        dbg_addr = AW'(ad);
        #1 check(nm, dbg_data, model_mem[ad]);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;

        // 1. Reset state and memory sweep.
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_flag", flag, 0);
        check("rst_out", out, 0);
        rst_n = 1;
        for (int i = 0; i < DEPTH; i++) dbg_chk("rst_mem", i);
        @(negedge clk);

        // 2. ADD 7F + 01 -> 80, C=0 Z=0 S=1 V=1.
        load(1, 'h7F);
        load(2, 'h01);
        issue(0, 1, 2, 3);
        wait_idle();
        dbg_addr = 3;
        #1 check("add_mem3", dbg_data, 'h80);
        check("add_flag", flag, 4'b0011);

        // 3. SUB equal operands into addr 4, then 0 - 1.
        @(negedge clk);
        load(4, 'h05);
        load(5, 'h05);
        issue(1, 4, 5, 4);
        wait_idle();
        dbg_addr = 4;
        #1 check("sub_zero_mem", dbg_data, 0);
        check("sub_zero_flag", flag, 4'b0100);
        @(negedge clk);
        load(10, 'h00);
        load(11, 'h01);
        issue(1, 10, 11, 12);
        wait_idle();
        dbg_addr = 12;
        #1 check("sub_borrow_mem", dbg_data, 'hFF);
        check("sub_borrow_flag", flag, 4'b1010);

        // 4. Invalid opcode: err with done, no write, flag unchanged.
        @(negedge clk);
        load(6, 'hAA);
        issue(12, 1, 2, 6);
        wait_idle();
        dbg_addr = 6;
        #1 check("inv_mem6", dbg_data, 'hAA);
        check("inv_flag", flag, 4'b1010);
        @(negedge clk);
        check("err_one_cycle", err, 0);
        check("done_one_cycle", done, 0);

        // 5. start/load_en while busy are ignored; start in the done cycle is taken.
        issue(0, 1, 2, 7);
        @(negedge clk);
        start = 1; opcode = 4'd1; addr1 = 10; addr2 = 10; addr3 = 10;
        load_en = 1; load_addr = 1; load_data = 'h55;
        @(posedge clk);
        #1 start = 0; load_en = 0;
        wait_idle();
        check("b2b_done_cycle", done, 1);
        issue(4, 1, 7, 8);
        wait_idle();
        @(negedge clk);
        dbg_chk("busy_load_ignored", 1);
        dbg_chk("busy_start_ignored", 10);
        dbg_chk("b2b_mem8", 8);

        // 6. Reset during EXEC aborts with no writeback and no done.
        @(negedge clk);
        load(13, 'h21);
        load(14, 'h12);
        issue(0, 13, 14, 9);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        #1 check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        sb.delete();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
        model_flag = '0;
        @(negedge clk);
        dbg_chk("abort_mem9", 9);
        dbg_chk("abort_mem13", 13);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        load(13, 'h21);
        load(14, 'h12);
        issue(0, 13, 14, 9);
        wait_idle();
        dbg_chk("post_abort_add", 9);

        // Randomised commands: fill memory, then mixed ops with aliasing and load+start.
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) load(i, int'($urandom_range(0, M - 1)));
        for (int n = 0; n < 80; n++) begin
            int op, a1, a2, a3;
            bit wl;
            op = int'($urandom_range(0, 15));
            a1 = int'($urandom_range(0, DEPTH - 1));
            a2 = int'($urandom_range(0, DEPTH - 1));
            a3 = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) == 0) begin a2 = a1; a3 = a1; end
            wl = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, M - 1)));
            issue(op, a1, a2, a3, wl, wl ? a1 : 0, int'($urandom_range(0, M - 1)));
            wait_idle();
            dbg_chk("rand_wb", a3);
        end

        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) dbg_chk("final_mem", i);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/exec_unit_seq.md
Name: exec_unit_seq

Overview:
Parametrised, sequenced execution unit. It owns a DEPTH-word operand memory and runs one ALU operation per command: read a from addr1, read b from addr2, execute opcode, write the result back to addr3. Commands use a start/busy/done handshake. A host load port preloads memory and a debug read port observes it. Sits between the instruction decoder and the data store as the datapath core.

Parameters:
DATA_W, 8, operand/result width (>=2)
ADDR_W, 5, memory address width
DEPTH, 32, memory words (<= 2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  command request, sampled in IDLE only
opcode  in  4  ALU operation
addr1  in  ADDR_W  operand a address
addr2  in  ADDR_W  operand b address
addr3  in  ADDR_W  result address
load_en  in  1  host write strobe
load_addr  in  ADDR_W  host write address
load_data  in  DATA_W  host write data
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  mem[dbg_addr], combinational
a  out  DATA_W  latched operand a
b  out  DATA_W  latched operand b
out  out  DATA_W  latched result
flag  out  4  {C,Z,S,V} of last valid op
busy  out  1  high when state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done for an invalid opcode

Behaviour:
- Reset (rst_n=0, async): state=IDLE; a, b, out=0; flag=4'b0000; done=err=0; every memory word=0.
- FSM: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE, one state per clock.
- IDLE: when start=1, capture opcode, addr1, addr2 and addr3 into internal registers, then go to RD_A. Command inputs are ignored outside IDLE.
- RD_A: a <= mem[addr1_q]. RD_B: b <= mem[addr2_q].
- EXEC: out <= result; next flags are computed into a holding register.
- WB: for a valid opcode, mem[addr3_q] <= out and flag <= next flags. For an invalid opcode there is no write, flag is unchanged and err is pulsed. done is pulsed on the same edge.
- Latency: start sampled at edge 0, done high between edge 4 and edge 5. busy high from edge 0 to edge 4. A new start is accepted in the cycle done is high.
- Opcodes (mod 2**DATA_W):
  0 ADD a+b
  1 SUB a-b
  2 AND
  3 OR
  4 XOR
  5 NOT a
  6 SHL a by 1
  7 SHR a by 1 (logical)
  8 INC a
  9 DEC a
  10 PASS a
  11-15 invalid
- Flags:
  - Z = (result==0). S = result MSB.
  - C: carry-out for ADD/INC; borrow (a<b unsigned) for SUB; borrow for DEC when a==0; bit shifted out for SHL/SHR; 0 otherwise.
  - V: two's-complement overflow for ADD/SUB/INC/DEC; 0 otherwise.
- Load port: load_en=1 writes mem[load_addr] only in IDLE; ignored while busy. If load_en and start are both high in IDLE, the load is performed and the command is accepted. RD_A/RD_B then see the loaded value.
- Addresses >= DEPTH: reads return 0 and writes are dropped, for load, writeback and debug alike.
- Aliasing: addr1, addr2 and addr3 may be equal. Operands are always read before writeback.
- Reset mid-operation: the FSM aborts immediately to IDLE, no writeback occurs, memory clears, done is not pulsed.

Test Plan:
1. Reset, then dbg_addr sweep 0..31 -> dbg_data=0 everywhere; flag=0; busy=0.
2. Load mem[1]=8'h7F, mem[2]=8'h01; opcode 0, addr 1,2,3; start -> done exactly 4 cycles after start; mem[3]=8'h80; flag C=0,Z=0,S=1,V=1.
3. Load mem[4]=8'h05, mem[5]=8'h05; SUB into addr 4 -> mem[4]=0, Z=1, C=0. Then SUB with a=8'h00, b=8'h01 -> result 8'hFF, C=1, S=1, V=0.
4. Opcode 12 with addr3=6 holding 8'hAA -> done and err pulse together; mem[6] stays 8'hAA; flag unchanged.
5. Pulse start and load_en during busy -> both ignored; memory unchanged; only one done. Then start in the done cycle -> accepted.
6. Deassert rst_n during EXEC -> busy=0 immediately, no done, target address reads 0. After release, a fresh ADD completes normally.
